// File: rtl/l1_dcache_resp_adapter_if.sv
// Handshake bundle between core request/response side, dcache response side and the adapter.
interface l1_dcache_resp_adapter_if;
  logic        req_valid_i;
  logic        req_gnt_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [2:0]  req_addr_lo_i;
  logic        req_signed_i;
  logic        dresp_rvalid_i;
  logic [63:0] dresp_rdata_i;
  logic        core_resp_valid_o;
  logic        core_resp_ready_i;
  logic [63:0] core_resp_data_o;
  logic        core_resp_is_store_o;
  logic        can_issue_o;
  logic [1:0]  outstanding_o;
  logic        err_o;

  modport master (
    output req_valid_i, req_gnt_i, req_we_i, req_size_i, req_addr_lo_i, req_signed_i,
    output dresp_rvalid_i, dresp_rdata_i, core_resp_ready_i,
    input  core_resp_valid_o, core_resp_data_o, core_resp_is_store_o,
    input  can_issue_o, outstanding_o, err_o
  );

  modport slave (
    input  req_valid_i, req_gnt_i, req_we_i, req_size_i, req_addr_lo_i, req_signed_i,
    input  dresp_rvalid_i, dresp_rdata_i, core_resp_ready_i,
    output core_resp_valid_o, core_resp_data_o, core_resp_is_store_o,
    output can_issue_o, outstanding_o, err_o
  );
endinterface

// File: rtl/l1_dcache_resp_adapter.sv
// Aligns/extends in-order dcache read words for the core, tracking up to two requests in flight.
// Optional macro L1_DRESP_BYPASS_EN forwards a response combinationally when the buffer is empty.
module l1_dcache_resp_adapter (
  input logic                      clk,
  input logic                      rst,
  l1_dcache_resp_adapter_if.slave  bus
);
  localparam int DATA_W = 64;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic [2:0] lo;
    logic       sgn;
  } meta_t;

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic [2:0] lo,
                                                   input logic sgn);
    logic [DATA_W-1:0] sh;
    logic [5:0]        amt;
    logic signed [DATA_W-1:0] ext;
    amt = (size == 2'd3) ? 6'd0 : {lo, 3'b000};
    sh  = raw >> amt;
    unique case (size)
      2'd0:    ext = {{56{sgn & sh[7]}},  sh[7:0]};
      2'd1:    ext = {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    ext = {{32{sgn & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  state_t            state;
  meta_t             meta_q [2];
  logic              meta_wr, meta_rd;
  logic [1:0]        out_cnt, out_nxt;
  logic [DATA_W-1:0] buf_data [2];
  logic              buf_st [2];
  logic              buf_wr, buf_rd;
  logic [1:0]        buf_cnt, buf_nxt;
  logic              err_q;

  logic              can_issue, push, bad_req, pop, orphan;
  logic              buf_push, buf_pop;
  logic [DATA_W-1:0] aligned;
  logic              aligned_st;
  logic [2:0]        sum_nxt;
  state_t            state_nxt;
  meta_t             head;

  assign can_issue  = (state != FULL);
  assign push       = bus.req_valid_i & bus.req_gnt_i & can_issue;
  assign bad_req    = bus.req_valid_i & bus.req_gnt_i & ~can_issue;
  assign pop        = bus.dresp_rvalid_i & (out_cnt != 2'd0);
  assign orphan     = bus.dresp_rvalid_i & (out_cnt == 2'd0);
  assign head       = meta_q[meta_rd];
  assign aligned    = head.we ? '0 : align_load(bus.dresp_rdata_i, head.size, head.lo, head.sgn);
  assign aligned_st = head.we;

`ifdef L1_DRESP_BYPASS_EN
  // An empty buffer lets the popped response reach the core in the same cycle.
  logic byp;
  assign byp      = pop & (buf_cnt == 2'd0);
  assign buf_push = pop & ~(byp & bus.core_resp_ready_i);
  assign buf_pop  = (buf_cnt != 2'd0) & bus.core_resp_ready_i;
  assign bus.core_resp_valid_o    = (buf_cnt != 2'd0) | byp;
  assign bus.core_resp_data_o     = byp ? aligned : buf_data[buf_rd];
  assign bus.core_resp_is_store_o = byp ? aligned_st : buf_st[buf_rd];
`else
  assign buf_push = pop;
  assign buf_pop  = (buf_cnt != 2'd0) & bus.core_resp_ready_i;
  assign bus.core_resp_valid_o    = (buf_cnt != 2'd0);
  assign bus.core_resp_data_o     = buf_data[buf_rd];
  assign bus.core_resp_is_store_o = buf_st[buf_rd];
`endif

  assign bus.can_issue_o   = can_issue;
  assign bus.outstanding_o = out_cnt;
  assign bus.err_o         = err_q;

  always_comb begin
    out_nxt = out_cnt;
    unique case ({push, pop})
      2'b10:   out_nxt = out_cnt + 2'd1;
      2'b01:   out_nxt = out_cnt - 2'd1;
      default: out_nxt = out_cnt;
    endcase
    buf_nxt = buf_cnt;
    unique case ({buf_push, buf_pop})
      2'b10:   buf_nxt = buf_cnt + 2'd1;
      2'b01:   buf_nxt = buf_cnt - 2'd1;
      default: buf_nxt = buf_cnt;
    endcase
    sum_nxt   = {1'b0, out_nxt} + {1'b0, buf_nxt};
    state_nxt = (sum_nxt == 3'd0) ? IDLE : (sum_nxt == 3'd1) ? BUSY : FULL;
  end

  // Control state, counters and the response buffer (cleared so outputs read zero after reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      meta_wr     <= 1'b0;
      meta_rd     <= 1'b0;
      out_cnt     <= 2'd0;
      buf_wr      <= 1'b0;
      buf_rd      <= 1'b0;
      buf_cnt     <= 2'd0;
      err_q       <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_st[0]   <= 1'b0;
      buf_st[1]   <= 1'b0;
    end else begin
      state   <= state_nxt;
      out_cnt <= out_nxt;
      buf_cnt <= buf_nxt;
      if (bad_req | orphan) err_q <= 1'b1;
      if (push) meta_wr <= ~meta_wr;
      if (pop)  meta_rd <= ~meta_rd;
      if (buf_push) begin
        buf_data[buf_wr] <= aligned;
        buf_st[buf_wr]   <= aligned_st;
        buf_wr           <= ~buf_wr;
      end
      if (buf_pop) buf_rd <= ~buf_rd;
    end
  end

  // Metadata storage is qualified by the counters, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) meta_q[meta_wr] <= '{we: bus.req_we_i, size: bus.req_size_i,
                                   lo: bus.req_addr_lo_i, sgn: bus.req_signed_i};
  end
endmodule

// File: tb/tb_l1_dcache_resp_adapter.sv
// Directed bench for l1_dcache_resp_adapter (default build) with an expected-response queue.
module tb_l1_dcache_resp_adapter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        st;
  } exp_t;
  exp_t sb [$];

  l1_dcache_resp_adapter_if bus ();

  l1_dcache_resp_adapter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [2:0] lo, input logic sgn);
    bus.req_valid_i   = 1'b1;
    bus.req_gnt_i     = 1'b1;
    bus.req_we_i      = we;
    bus.req_size_i    = size;
    bus.req_addr_lo_i = lo;
    bus.req_signed_i  = sgn;
    tick();
    bus.req_valid_i   = 1'b0;
    bus.req_gnt_i     = 1'b0;
  endtask

  task automatic rv(input logic [63:0] raw, input logic [63:0] exp, input logic st, input logic expect_out);
    bus.dresp_rvalid_i = 1'b1;
    bus.dresp_rdata_i  = raw;
    if (expect_out) sb.push_back('{d: exp, st: st});
    tick();
    bus.dresp_rvalid_i = 1'b0;
  endtask

  task automatic resp_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(bus.core_resp_valid_o), 64'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, bus.core_resp_data_o, e.d);
      chk({tag, "_st"}, 64'(bus.core_resp_is_store_o), 64'(e.st));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_gnt_i = 1'b0; bus.req_we_i = 1'b0;
    bus.req_size_i = 2'd0; bus.req_addr_lo_i = 3'd0; bus.req_signed_i = 1'b0;
    bus.dresp_rvalid_i = 1'b0; bus.dresp_rdata_i = '0; bus.core_resp_ready_i = 1'b0;
    tick(); tick();
    chk("rst_valid", 64'(bus.core_resp_valid_o), 64'd0);
    chk("rst_out", 64'(bus.outstanding_o), 64'd0);
    chk("rst_can_issue", 64'(bus.can_issue_o), 64'd1);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_data", bus.core_resp_data_o, 64'd0);
    chk("rst_st", 64'(bus.core_resp_is_store_o), 64'd0);
    rst = 1'b1;
    tick();

    // Signed byte at addr_lo=3
    issue(1'b0, 2'd0, 3'd3, 1'b1);
    chk("sb_out1", 64'(bus.outstanding_o), 64'd1);
    chk("sb_can_issue", 64'(bus.can_issue_o), 64'd1);
    rv(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
    resp_check("sbyte");
    chk("sb_out0", 64'(bus.outstanding_o), 64'd0);
    bus.core_resp_ready_i = 1'b1;
    tick();
    chk("sb_drained", 64'(bus.core_resp_valid_o), 64'd0);
    bus.core_resp_ready_i = 1'b0;

    // Unsigned word at addr_lo=4
    issue(1'b0, 2'd2, 3'd4, 1'b0);
    rv(64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 1'b0, 1'b1);
    resp_check("uword");
    bus.core_resp_ready_i = 1'b1;
    tick();
    bus.core_resp_ready_i = 1'b0;

    // Signed halfword at addr_lo=6
    issue(1'b0, 2'd1, 3'd6, 1'b1);
    rv(64'hFFFE_1234_5678_9ABC, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    resp_check("shalf");
    bus.core_resp_ready_i = 1'b1;
    tick();
    bus.core_resp_ready_i = 1'b0;

    // Fill to FULL, overflow grant ignored, drain in order
    issue(1'b0, 2'd1, 3'd2, 1'b0);
    issue(1'b0, 2'd3, 3'd5, 1'b1);
    chk("full_can_issue", 64'(bus.can_issue_o), 64'd0);
    chk("full_out", 64'(bus.outstanding_o), 64'd2);
    chk("full_err0", 64'(bus.err_o), 64'd0);
    issue(1'b1, 2'd0, 3'd0, 1'b0);
    chk("ovf_err", 64'(bus.err_o), 64'd1);
    chk("ovf_out", 64'(bus.outstanding_o), 64'd2);
    rv(64'h0000_0000_DEAD_0000, 64'h0000_0000_0000_DEAD, 1'b0, 1'b1);
    rv(64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 1'b0, 1'b1);
    chk("buf_out", 64'(bus.outstanding_o), 64'd0);
    chk("buf_can_issue", 64'(bus.can_issue_o), 64'd0);
    resp_check("full0");
    bus.core_resp_ready_i = 1'b1;
    tick();
    resp_check("full1");
    tick();
    chk("full_drained", 64'(bus.core_resp_valid_o), 64'd0);
    chk("full_can_issue1", 64'(bus.can_issue_o), 64'd1);
    bus.core_resp_ready_i = 1'b0;
    do_reset();
    chk("err_clr", 64'(bus.err_o), 64'd0);

    // Push and pop in the same cycle
    issue(1'b0, 2'd2, 3'd0, 1'b0);
    bus.req_valid_i = 1'b1; bus.req_gnt_i = 1'b1; bus.req_we_i = 1'b0;
    bus.req_size_i = 2'd0; bus.req_addr_lo_i = 3'd7; bus.req_signed_i = 1'b0;
    rv(64'h1111_2222_F333_4444, 64'h0000_0000_F333_4444, 1'b0, 1'b1);
    bus.req_valid_i = 1'b0; bus.req_gnt_i = 1'b0;
    chk("pp_out", 64'(bus.outstanding_o), 64'd1);
    resp_check("pp0");
    bus.core_resp_ready_i = 1'b1;
    rv(64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 1'b0, 1'b1);
    resp_check("pp1");
    tick();
    chk("pp_drained", 64'(bus.core_resp_valid_o), 64'd0);
    bus.core_resp_ready_i = 1'b0;

    // Orphan rvalid sets sticky error
    rv(64'h1234, 64'd0, 1'b0, 1'b0);
    chk("orph_err", 64'(bus.err_o), 64'd1);
    chk("orph_valid", 64'(bus.core_resp_valid_o), 64'd0);
    tick();
    chk("orph_sticky", 64'(bus.err_o), 64'd1);
    do_reset();
    chk("orph_clr", 64'(bus.err_o), 64'd0);

    // Reset mid-flight discards metadata
    issue(1'b0, 2'd3, 3'd0, 1'b0);
    do_reset();
    chk("mid_out", 64'(bus.outstanding_o), 64'd0);
    rv(64'h5555, 64'd0, 1'b0, 1'b0);
    chk("mid_err", 64'(bus.err_o), 64'd1);
    chk("mid_valid", 64'(bus.core_resp_valid_o), 64'd0);
    do_reset();

    // Store acknowledge
    issue(1'b1, 2'd3, 3'd0, 1'b0);
    rv(64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b1, 1'b1);
    resp_check("store");
    bus.core_resp_ready_i = 1'b1;
    tick();
    chk("store_drained", 64'(bus.core_resp_valid_o), 64'd0);
    chk("store_err", 64'(bus.err_o), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_dcache_resp_adapter.md
L1_DCACHE_RESP_ADAPTER -- requirements
Module: l1_dcache_resp_adapter

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 req_valid_i  in  1  core request valid toward dcache (load or store).
REQ-004 req_gnt_i  in  1  dcache grant for the current request.
REQ-005 req_we_i  in  1  1 = store, 0 = load.
REQ-006 req_size_i  in  2  0=B, 1=H, 2=W, 3=D.
REQ-007 req_addr_lo_i  in  3  physical address bits [2:0].
REQ-008 req_signed_i  in  1  1 = sign-extend load result.
REQ-009 dresp_rvalid_i  in  1  dcache response valid; one per granted request, in order; cannot be stalled.
REQ-010 dresp_rdata_i  in  64  raw 64-bit dcache read word.
REQ-011 core_resp_valid_o  out  1  aligned response valid to core.
REQ-012 core_resp_ready_i  in  1  core accepts response.
REQ-013 core_resp_data_o  out  64  aligned, extended load data; 0 for stores.
REQ-014 core_resp_is_store_o  out  1  response is a store acknowledge.
REQ-015 can_issue_o  out  1  adapter can absorb one more granted request.
REQ-016 outstanding_o  out  2  granted requests awaiting dresp_rvalid_i.
REQ-017 err_o  out  1  sticky: rvalid received with no outstanding request.

Function
REQ-018 Metadata FIFO, depth 2, entry {we, size, addr_lo, signed}; push when req_valid_i & req_gnt_i & can_issue_o.
REQ-019 req_valid_i & req_gnt_i while can_issue_o=0 SHALL be ignored (no push) and SHALL set err_o.
REQ-020 Pop metadata FIFO on dresp_rvalid_i when outstanding_o>0; push and pop in the same cycle leave outstanding_o unchanged.
REQ-021 Alignment: shift dresp_rdata_i right by 8*addr_lo (size 3 uses shift 0), keep low 1/2/4/8 bytes, sign-extend if signed else zero-extend; store entries produce data 0, is_store 1.
REQ-022 Response buffer: 2-entry FIFO of {data, is_store}; written by each popped response, read when core_resp_valid_o & core_resp_ready_i; simultaneous write and read both take effect.
REQ-023 core_resp_valid_o = response buffer non-empty; core_resp_data_o/is_store_o = head entry, held stable while valid & !ready.
REQ-024 can_issue_o = (outstanding_o + buffer occupancy) < 2, combinational from registered counts.
REQ-025 FSM states IDLE (both counts 0), BUSY (sum 1), FULL (sum 2); transitions by per-cycle net change in sum; can_issue_o=0 only in FULL.
REQ-026 dresp_rvalid_i with outstanding_o=0: data discarded, err_o set, no buffer write.
REQ-027 Latency without bypass: dresp_rvalid_i in cycle N -> core_resp_valid_o in cycle N+1.

Reset
REQ-028 rst=0 at a clock edge SHALL clear both FIFOs, FSM to IDLE, err_o=0, core_resp_valid_o=0, outstanding_o=0, can_issue_o=1, core_resp_data_o=0, core_resp_is_store_o=0.
REQ-029 Reset mid-operation SHALL discard all in-flight metadata and buffered responses; later rvalids for them SHALL set err_o.

Configuration
REQ-030 Macro L1_DRESP_BYPASS_EN: when defined, if buffer empty and dresp_rvalid_i with valid metadata, aligned data drives outputs combinationally in cycle N; if core_resp_ready_i=1 the buffer is not written.
REQ-031 Without L1_DRESP_BYPASS_EN all responses pass through the buffer (REQ-027); core_resp outputs are purely registered.

Verification
REQ-032 Load size=0, addr_lo=3, signed=1, rdata=0x0000_0000_8000_0000 -> core_resp_data_o=0xFFFF_FFFF_FFFF_FF80 one cycle after rvalid (no bypass).
REQ-033 Load size=2, addr_lo=4, signed=0, rdata=0x89AB_CDEF_0000_0000 -> data=0x0000_0000_89AB_CDEF.
REQ-034 Two grants, ready=0 -> can_issue_o=0 (FULL); two rvalids buffered; ready=1 -> two responses in order on consecutive cycles, can_issue_o returns to 1.
REQ-035 rvalid with outstanding_o=0 -> err_o=1 sticky, core_resp_valid_o stays 0; rst=0 -> err_o=0.
REQ-036 Store grant then rvalid -> core_resp_is_store_o=1, data=0; with L1_DRESP_BYPASS_EN and ready=1, valid in same cycle as rvalid.
